// File: rtl/ureg_pkg.sv
// ureg_pkg: shared encodings for universal_register.
// Holds the mode encodings, the FSM state type and the state constants.
package ureg_pkg;

    // Operating mode applied in IDLE each cycle
    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } ureg_mode_e;

    // Auto-shift sequencer state
    typedef logic [0:0] ureg_state_t;

    localparam ureg_state_t ST_IDLE = 1'b0;
    localparam ureg_state_t ST_AUTO = 1'b1;

    // Direction latched for an auto-shift sequence
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // True for the two shifting modes
    function automatic logic is_shift_mode(input logic [1:0] mode);
        return (mode == MODE_SHL) || (mode == MODE_SHR);
    endfunction

endpackage : ureg_pkg

// File: rtl/universal_register.sv
// universal_register: parametrised data-holding / serialising stage.
// Lane-masked parallel load, serial shift left/right and an auto-shift
// sequencer (start -> N shifts -> done). Synchronous active-low reset.
// Optional build macro: UREG_PARITY_EN adds o_parity = ^o_data_out.
module universal_register
    import ureg_pkg::*;
#(
    parameter int              WIDTH   = 8,
    parameter int              LANE_W  = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int             LANES   = WIDTH / LANE_W,
    localparam int             CW      = $clog2(WIDTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_sync_rst,
    input  logic [1:0]        i_mode,
    input  logic [LANES-1:0]  i_lane_en,
    input  logic [WIDTH-1:0]  i_data_in,
    input  logic              i_ser_in,
    input  logic              i_start,
    input  logic [CW-1:0]     i_shift_n,
    output logic [WIDTH-1:0]  o_data_out,
    output logic              o_ser_out,
    output logic              o_busy,
    output logic              o_done
`ifdef UREG_PARITY_EN
    ,
    output logic              o_parity
`endif
);

    // Shift count saturates at the register width
    localparam logic [CW-1:0] W_MAX_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] W_ONE     = CW'(1);

    logic [WIDTH-1:0] r_data;
    logic             r_ser;
    logic             r_done;
    logic             r_dir;
    ureg_state_t      r_state;
    logic [CW-1:0]    r_rem;

    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_shl_val;
    logic [WIDTH-1:0] w_shr_val;
    logic             w_shift_dir;
    logic [WIDTH-1:0] w_shift_val;
    logic             w_shift_out;
    logic [CW-1:0]    w_cnt;
    logic             w_start_seq;

    // Lane-masked load: disabled lanes keep their current contents
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign w_load_val[g*LANE_W +: LANE_W] =
            i_lane_en[g] ? i_data_in[g*LANE_W +: LANE_W] : r_data[g*LANE_W +: LANE_W];
    end

    // Both shift candidates; the FSM picks one
    assign w_shl_val = {r_data[WIDTH-2:0], i_ser_in};
    assign w_shr_val = {i_ser_in, r_data[WIDTH-1:1]};

    // In AUTO the latched direction rules; otherwise the live mode does
    assign w_shift_dir = (r_state == ST_AUTO) ? r_dir : (i_mode == MODE_SHR);

    // Select shifted value and the bit that falls off the end
    always_comb begin
        w_shift_val = w_shl_val;
        w_shift_out = r_data[WIDTH-1];
        if (w_shift_dir == DIR_RIGHT) begin
            w_shift_val = w_shr_val;
            w_shift_out = r_data[0];
        end
    end

    assign w_cnt       = (i_shift_n > W_MAX_CNT) ? W_MAX_CNT : i_shift_n;
    assign w_start_seq = i_start && is_shift_mode(i_mode);

    // Register contents, serial output and sequencer state
    always_ff @(posedge i_clk) begin
        if (!i_sync_rst) begin
            r_data  <= RST_VAL;
            r_ser   <= 1'b0;
            r_done  <= 1'b0;
            r_dir   <= DIR_LEFT;
            r_state <= ST_IDLE;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_seq) begin
                        r_dir <= (i_mode == MODE_SHR);
                        if (w_cnt == '0) begin
                            // Empty sequence: report completion, touch nothing
                            r_done <= 1'b1;
                        end else begin
                            // The start edge performs shift 1
                            r_data <= w_shift_val;
                            r_ser  <= w_shift_out;
                            if (w_cnt == W_ONE) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_AUTO;
                                r_rem   <= w_cnt - W_ONE;
                            end
                        end
                    end else begin
                        case (i_mode)
                            MODE_LOAD: r_data <= w_load_val;
                            MODE_SHL, MODE_SHR: begin
                                r_data <= w_shift_val;
                                r_ser  <= w_shift_out;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_AUTO: begin
                    // Inputs other than ser_in are ignored until the last shift
                    r_data <= w_shift_val;
                    r_ser  <= w_shift_out;
                    r_rem  <= r_rem - W_ONE;
                    if (r_rem == W_ONE) begin
                        r_state <= ST_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_data_out = r_data;
    assign o_ser_out  = r_ser;
    assign o_busy     = (r_state == ST_AUTO);
    assign o_done     = r_done;

`ifdef UREG_PARITY_EN
    assign o_parity = ^r_data;
`endif

endmodule : universal_register

// File: tb/tb_universal_register.sv
// tb_universal_register: directed bench for universal_register.
// Two instances: 8-bit single-lane and 16-bit two-lane. Expected results
// are queued before each edge and popped/compared just after it.
`timescale 1ns/1ps
module tb_universal_register;

    logic        clk = 1'b0;
    logic        rst;
    // 8-bit instance
    logic [1:0]  mode;
    logic [0:0]  lane;
    logic [7:0]  din;
    logic        sin;
    logic        start;
    logic [3:0]  shn;
    logic [7:0]  dout;
    logic        sout, busy, done;
    // 16-bit instance
    logic [1:0]  mode16;
    logic [1:0]  lane16;
    logic [15:0] din16;
    logic [15:0] dout16;
    logic        sout16, busy16, done16;
`ifdef UREG_PARITY_EN
    logic        par, par16;
`endif

    always #5 clk = ~clk;

    universal_register #(.WIDTH(8), .LANE_W(8), .RST_VAL(8'h00)) u_d8 (
        .i_clk(clk), .i_sync_rst(rst), .i_mode(mode), .i_lane_en(lane),
        .i_data_in(din), .i_ser_in(sin), .i_start(start), .i_shift_n(shn),
        .o_data_out(dout), .o_ser_out(sout), .o_busy(busy), .o_done(done)
`ifdef UREG_PARITY_EN
        , .o_parity(par)
`endif
    );

    universal_register #(.WIDTH(16), .LANE_W(8), .RST_VAL(16'h0000)) u_d16 (
        .i_clk(clk), .i_sync_rst(rst), .i_mode(mode16), .i_lane_en(lane16),
        .i_data_in(din16), .i_ser_in(1'b0), .i_start(1'b0), .i_shift_n(5'd0),
        .o_data_out(dout16), .o_ser_out(sout16), .o_busy(busy16), .o_done(done16)
`ifdef UREG_PARITY_EN
        , .o_parity(par16)
`endif
    );

    typedef struct {
        string       tag;
        bit          wide;
        logic [15:0] data;
        logic        ser;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp8(input string tag, input logic [7:0] d, input logic s,
                        input logic b, input logic dn);
        exp_t e;
        e.tag = tag; e.wide = 1'b0; e.data = {8'h00, d};
        e.ser = s; e.busy = b; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic exp16(input string tag, input logic [15:0] d);
        exp_t e;
        e.tag = tag; e.wide = 1'b1; e.data = d;
        e.ser = 1'b0; e.busy = 1'b0; e.done = 1'b0;
        sb.push_back(e);
    endtask

    // Advance one edge, then drain the scoreboard against the outputs
    task automatic cyc();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.wide) begin
                chk({e.tag, ".d16"}, dout16, e.data);
            end else begin
                chk({e.tag, ".data"}, {8'h00, dout}, e.data);
                chk({e.tag, ".ser"},  {15'h0, sout}, {15'h0, e.ser});
                chk({e.tag, ".busy"}, {15'h0, busy}, {15'h0, e.busy});
                chk({e.tag, ".done"}, {15'h0, done}, {15'h0, e.done});
            end
        end
    endtask

    initial begin
        rst = 1'b0; mode = 2'b01; lane = 1'b1; din = 8'hFF; sin = 1'b0;
        start = 1'b0; shn = 4'd0;
        mode16 = 2'b01; lane16 = 2'b11; din16 = 16'hFFFF;

        // Reset holds despite LOAD
        exp8("rst0", 8'h00, 0, 0, 0); exp16("rst0", 16'h0000); cyc();
        exp8("rst1", 8'h00, 0, 0, 0); exp16("rst1", 16'h0000); cyc();
`ifdef UREG_PARITY_EN
        chk("par_rst", {15'h0, par}, 16'h0000);
`endif
        // Release: load lands one edge later
        rst = 1'b1; din16 = 16'h1234;
        exp8("rel_load", 8'hFF, 0, 0, 0); exp16("load1234", 16'h1234); cyc();

        // Lane-masked load on 16-bit, plain load on 8-bit
        din16 = 16'hABCD; lane16 = 2'b01; din = 8'h81;
        exp8("load81", 8'h81, 0, 0, 0); exp16("lane01", 16'h12CD); cyc();
        mode16 = 2'b00; din16 = 16'h5555;
        exp16("hold16", 16'h12CD);

        // Manual shifts
        mode = 2'b10; sin = 1'b0;
        exp8("shl", 8'h02, 1, 0, 0); cyc();
        mode = 2'b11; sin = 1'b1;
        exp8("shr", 8'h81, 0, 0, 0); cyc();
        mode = 2'b00; din = 8'h33;
        exp8("hold", 8'h81, 0, 0, 0); cyc();
        mode = 2'b01; lane = 1'b0;
        exp8("lane_off", 8'h81, 0, 0, 0); cyc();

        // Auto SHR x4 from A5; mode/data change mid-sequence must be ignored
        lane = 1'b1; din = 8'hA5;
        exp8("loadA5", 8'hA5, 0, 0, 0); cyc();
        start = 1'b1; mode = 2'b11; shn = 4'd4; sin = 1'b0;
        exp8("a4_s1", 8'h52, 1, 1, 0); cyc();
        start = 1'b0; mode = 2'b01; din = 8'h00;
        exp8("a4_s2", 8'h29, 0, 1, 0); cyc();
        exp8("a4_s3", 8'h14, 1, 1, 0); cyc();
        exp8("a4_done", 8'h0A, 0, 0, 1); cyc();
        mode = 2'b00;
        exp8("a4_after", 8'h0A, 0, 0, 0); cyc();

        // Zero-length sequence
        start = 1'b1; mode = 2'b10; shn = 4'd0; sin = 1'b1;
        exp8("n0_done", 8'h0A, 0, 0, 1); cyc();
        start = 1'b0; mode = 2'b00;
        exp8("n0_after", 8'h0A, 0, 0, 0); cyc();

        // Start ignored in LOAD mode
        start = 1'b1; mode = 2'b01; din = 8'h01; shn = 4'd3;
        exp8("start_load", 8'h01, 0, 0, 0); cyc();

        // shift_n=9 clamps to 8 shifts
        mode = 2'b10; shn = 4'd9; sin = 1'b0;
        exp8("c_s1", 8'h02, 0, 1, 0); cyc();
        start = 1'b0; mode = 2'b00;
        for (int k = 2; k <= 7; k++) begin
            exp8($sformatf("c_s%0d", k), 8'(1 << k), 0, 1, 0); cyc();
        end
        exp8("c_done", 8'h00, 1, 0, 1); cyc();
        sin = 1'b1;
        exp8("c_after", 8'h00, 1, 0, 0); cyc();

        // Back-to-back: new start in the done cycle
        mode = 2'b01; din = 8'hF0;
        exp8("loadF0", 8'hF0, 1, 0, 0); cyc();
        start = 1'b1; mode = 2'b11; shn = 4'd2; sin = 1'b1;
        exp8("b2_s1", 8'hF8, 0, 1, 0); cyc();
        start = 1'b0; mode = 2'b00;
        exp8("b2_done", 8'hFC, 0, 0, 1); cyc();
        start = 1'b1; mode = 2'b10; shn = 4'd1; sin = 1'b0;
        exp8("b1_done", 8'hF8, 1, 0, 1); cyc();
        start = 1'b0; mode = 2'b00;
        exp8("b1_after", 8'hF8, 1, 0, 0); cyc();

        // Reset during AUTO aborts without done
        start = 1'b1; mode = 2'b11; shn = 4'd8; sin = 1'b0;
        exp8("ra_s1", 8'h7C, 0, 1, 0); cyc();
        start = 1'b0; rst = 1'b0;
        exp8("ra_rst", 8'h00, 0, 0, 0); exp16("ra_rst", 16'h0000); cyc();
        mode = 2'b10; sin = 1'b1;
        exp8("ra_rst2", 8'h00, 0, 0, 0); cyc();
        rst = 1'b1; mode = 2'b00;
        exp8("ra_rel", 8'h00, 0, 0, 0); cyc();
        exp8("ra_idle", 8'h00, 0, 0, 0); cyc();

`ifdef UREG_PARITY_EN
        mode = 2'b01; din = 8'h07;
        exp8("load07", 8'h07, 0, 0, 0); cyc();
        chk("par07", {15'h0, par}, 16'h0001);
        din = 8'h06;
        exp8("load06", 8'h06, 0, 0, 0); cyc();
        chk("par06", {15'h0, par}, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_universal_register
